// File: rtl/udp_tx_framer.sv
`timescale 1ns/1ps
// udp_tx_framer: builds Ethernet/IPv4/UDP transmit frames from a payload byte
// stream and emits them one byte per clock (GMII-style) to the RGMII TX stage.
// Frame: 7x0x55, 0xD5, 42-byte header, N payload bytes, [pad], 4-byte FCS, IFG.
//
// Ports:
//   clk_i, arstn_i           TX byte clock, async active-low reset
//   host_mac_i/fpga_mac_i    destination / source MAC
//   host_ip_i/fpga_ip_i      destination / source IPv4 address
//   host_port_i/fpga_port_i  destination / source UDP port
//   payload_bytes_i          payload length N (1..1472), latched at frame start
//   s_axis_*                 payload byte stream (tready only while sending payload)
//   tx_data_o/tx_en_o/tx_er_o  GMII-style byte output
//   busy_o                   frame in progress, including inter-frame gap
//   frame_done_o             pulse on the last FCS byte
//   underflow_o              pulse when a frame is aborted for lack of payload
//
// Build option: define UDP_TX_PAD_EN to zero-pad frames up to the 60-byte
// Ethernet minimum (before FCS). Default build sends short frames unpadded.
module udp_tx_framer #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned IP_TTL    = 64
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [47:0] host_mac_i,
    input  logic [47:0] fpga_mac_i,
    input  logic [31:0] host_ip_i,
    input  logic [31:0] fpga_ip_i,
    input  logic [15:0] host_port_i,
    input  logic [15:0] fpga_port_i,
    input  logic [15:0] payload_bytes_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_en_o,
    output logic        tx_er_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underflow_o
);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StSfd, StHeader, StPayload, StFcs, StIfg
`ifdef UDP_TX_PAD_EN
        , StPad
`endif
    } state_e;

    localparam logic [15:0] IfgLast = 16'(IFG_BYTES - 1);

    state_e      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_id, w_id_nxt;
    logic [15:0] r_csum, w_csum_nxt;
    logic [31:0] r_crc, w_crc_nxt;
    logic        w_latch;

    logic [47:0] r_dmac, r_smac;
    logic [31:0] r_dip, r_sip;
    logic [15:0] r_dport, r_sport, r_len;

    logic [15:0]       w_ip_len, w_udp_len;
    logic [19:0]       w_sum;
    logic [16:0]       w_fold1;
    logic [15:0]       w_fold2;
    logic [41:0][7:0]  w_hdr;
    logic [7:0]        w_hdr_byte;
    logic [31:0]       w_fcs;

    // Reflected CRC-32 (0xEDB88320), one byte per call.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_ip_len  = 16'd28 + r_len;
    assign w_udp_len = 16'd8 + r_len;

    // Ten header words with checksum field zero; at most 9 non-zero terms so 20 bits suffice.
    assign w_sum = 20'(16'h4500) + 20'(w_ip_len) + 20'(r_id) + 20'(16'h4000)
                 + 20'({8'(IP_TTL), 8'h11})
                 + 20'(r_sip[31:16]) + 20'(r_sip[15:0])
                 + 20'(r_dip[31:16]) + 20'(r_dip[15:0]);
    assign w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);

    // Fields are latched at frame start, so recomputing every preamble cycle settles well
    // before the header needs it.
    assign w_csum_nxt = (r_state == StPreamble) ? ~w_fold2 : r_csum;

    assign w_hdr = {r_dmac, r_smac, 16'h0800,
                    8'h45, 8'h00, w_ip_len, r_id, 16'h4000, 8'(IP_TTL), 8'h11, r_csum,
                    r_sip, r_dip,
                    r_sport, r_dport, w_udp_len, 16'h0000};

    assign w_hdr_byte = w_hdr[6'd41 - r_cnt[5:0]];
    assign w_fcs      = ~r_crc;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_id    <= '0;
            r_csum  <= '0;
            r_crc   <= '0;
            r_dmac  <= '0;
            r_smac  <= '0;
            r_dip   <= '0;
            r_sip   <= '0;
            r_dport <= '0;
            r_sport <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_csum  <= w_csum_nxt;
            r_crc   <= w_crc_nxt;
            if (w_latch) begin
                r_dmac  <= host_mac_i;
                r_smac  <= fpga_mac_i;
                r_dip   <= host_ip_i;
                r_sip   <= fpga_ip_i;
                r_dport <= host_port_i;
                r_sport <= fpga_port_i;
                r_len   <= payload_bytes_i;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 16'd1;
        w_id_nxt        = r_id;
        w_crc_nxt       = r_crc;
        w_latch         = 1'b0;
        s_axis_tready_o = 1'b0;
        tx_data_o       = 8'h00;
        tx_en_o         = 1'b0;
        tx_er_o         = 1'b0;
        frame_done_o    = 1'b0;
        underflow_o     = 1'b0;
        busy_o          = (r_state != StIdle);

        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (s_axis_tvalid_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = StPreamble;
                end
            end
            StPreamble: begin
                tx_en_o   = 1'b1;
                tx_data_o = 8'h55;
                if (r_cnt == 16'd6) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StSfd;
                end
            end
            StSfd: begin
                tx_en_o     = 1'b1;
                tx_data_o   = 8'hD5;
                w_cnt_nxt   = '0;
                w_crc_nxt   = 32'hFFFF_FFFF;
                w_state_nxt = StHeader;
            end
            StHeader: begin
                tx_en_o   = 1'b1;
                tx_data_o = w_hdr_byte;
                w_crc_nxt = f_crc_byte(r_crc, w_hdr_byte);
                if (r_cnt == 16'd41) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StPayload;
                end
            end
            StPayload: begin
                s_axis_tready_o = 1'b1;
                tx_en_o         = 1'b1;
                if (s_axis_tvalid_i) begin
                    tx_data_o = s_axis_tdata_i;
                    w_crc_nxt = f_crc_byte(r_crc, s_axis_tdata_i);
                    if (r_cnt == r_len - 16'd1) begin
                        w_cnt_nxt   = '0;
`ifdef UDP_TX_PAD_EN
                        w_state_nxt = (r_len < 16'd18) ? StPad : StFcs;
`else
                        w_state_nxt = StFcs;
`endif
                    end
                end else begin
                    // Source ran dry: poison this byte, drop FCS, go straight to the gap.
                    tx_er_o     = 1'b1;
                    underflow_o = 1'b1;
                    w_cnt_nxt   = '0;
                    w_id_nxt    = r_id + 16'd1;
                    w_state_nxt = StIfg;
                end
            end
`ifdef UDP_TX_PAD_EN
            StPad: begin
                tx_en_o   = 1'b1;
                w_crc_nxt = f_crc_byte(r_crc, 8'h00);
                if (r_cnt == 16'd17 - r_len) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StFcs;
                end
            end
`endif
            StFcs: begin
                tx_en_o   = 1'b1;
                tx_data_o = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt == 16'd3) begin
                    frame_done_o = 1'b1;
                    w_cnt_nxt    = '0;
                    w_id_nxt     = r_id + 16'd1;
                    w_state_nxt  = StIfg;
                end
            end
            StIfg: begin
                if (r_cnt == IfgLast) begin
                    w_cnt_nxt = '0;
                    // Chain straight into the next frame so the gap is exactly IFG_BYTES.
                    if (s_axis_tvalid_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = StPreamble;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule
